// File: rtl/sram_id_slot_scheduler.sv
// Packet-ID slot table for the SRAM FIFO: serial lookup/allocate through one
// shared comparator (one slot per cycle), plus slot release and occupancy count.
module sram_id_slot_scheduler #(
  parameter int unsigned NUM_SLOTS = 14,
  parameter int unsigned ID_W      = 16,
  parameter int unsigned SLOT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ID_W-1:0]   req_id,
  input  logic              req_alloc,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [SLOT_W-1:0] resp_slot,
  output logic              resp_hit,
  output logic              resp_alloc,
  output logic              resp_full,
  output logic              resp_err,
  input  logic              rel_valid,
  output logic              rel_ready,
  input  logic [SLOT_W-1:0] rel_slot,
  output logic [SLOT_W-1:0] used_cnt
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e            state_q;
  logic [SLOT_W-1:0] scan_idx_q;
  logic [SLOT_W-1:0] empty_q;
  logic [SLOT_W-1:0] used_q;
  logic [ID_W-1:0]   id_q;
  logic              alloc_q;
  logic [ID_W-1:0]   slots_q [NUM_SLOTS];
  logic [SLOT_W-1:0] resp_slot_q;
  logic              resp_hit_q;
  logic              resp_alloc_q;
  logic              resp_full_q;
  logic              resp_err_q;

  logic [SLOT_W-1:0] cur_pos;
  logic [ID_W-1:0]   cur_id;
  logic              cur_hit;
  logic [SLOT_W-1:0] empty_sel;
  logic              rel_ok;
  logic [SLOT_W-1:0] rel_pos;
  logic              rel_live;

  // Shared comparator and first-empty tracking, including the slot under scan.
  always_comb begin
    cur_pos   = (scan_idx_q == '0) ? '0 : scan_idx_q - 1'b1;
    cur_id    = slots_q[cur_pos];
    cur_hit   = (cur_id == id_q);
    empty_sel = empty_q;
    if (empty_q == '0 && cur_id == '0) begin
      empty_sel = scan_idx_q;
    end
    rel_ok   = (rel_slot != '0) && (rel_slot <= LAST_SLOT);
    rel_pos  = rel_ok ? rel_slot - 1'b1 : '0;
    rel_live = rel_ok && (slots_q[rel_pos] != '0);
  end

  assign req_ready  = reset && (state_q == IDLE) && !rel_valid;
  assign rel_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_slot  = resp_slot_q;
  assign resp_hit   = resp_hit_q;
  assign resp_alloc = resp_alloc_q;
  assign resp_full  = resp_full_q;
  assign resp_err   = resp_err_q;
  assign used_cnt   = used_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      scan_idx_q   <= '0;
      empty_q      <= '0;
      used_q       <= '0;
      id_q         <= '0;
      alloc_q      <= 1'b0;
      resp_slot_q  <= '0;
      resp_hit_q   <= 1'b0;
      resp_alloc_q <= 1'b0;
      resp_full_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (rel_valid) begin
            if (rel_live) begin
              slots_q[rel_pos] <= '0;
              used_q           <= used_q - 1'b1;
            end
          end else if (req_valid) begin
            id_q         <= req_id;
            alloc_q      <= req_alloc;
            empty_q      <= '0;
            resp_slot_q  <= '0;
            resp_hit_q   <= 1'b0;
            resp_alloc_q <= 1'b0;
            resp_full_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            if (req_id == '0) begin
              resp_err_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              scan_idx_q <= SLOT_W'(1);
              state_q    <= SCAN;
            end
          end
        end
        SCAN: begin
          if (cur_hit) begin
            resp_hit_q  <= 1'b1;
            resp_slot_q <= scan_idx_q;
            scan_idx_q  <= '0;
            state_q     <= DONE;
          end else if (scan_idx_q == LAST_SLOT) begin
            // No hit anywhere: only now is it safe to allocate.
            if (alloc_q && empty_sel != '0) begin
              slots_q[empty_sel - 1'b1] <= id_q;
              used_q                    <= used_q + 1'b1;
              resp_alloc_q              <= 1'b1;
              resp_slot_q               <= empty_sel;
            end else if (alloc_q) begin
              resp_full_q <= 1'b1;
            end
            scan_idx_q <= '0;
            state_q    <= DONE;
          end else begin
            empty_q    <= empty_sel;
            scan_idx_q <= scan_idx_q + 1'b1;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_slot_q  <= '0;
            resp_hit_q   <= 1'b0;
            resp_alloc_q <= 1'b0;
            resp_full_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
